// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if
//   Bundles the command handshake and the datapath control word between a
//   command source / datapath and the datapath_sequencer.
//   Ports carried:
//     cmd_valid, cmd_op[2:0], cmd_data[W-1:0]  command from the source
//     cmd_ready, busy, done                    sequencer status
//     x[W-1:0], l1, l2, s1[1:0], s2[1:0], f    datapath control word
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high; cmd_ready is high only while the sequencer is
//   idle, and command inputs are don't-care whenever cmd_ready is low.
//   Modports: slave = sequencer side, master = command source / datapath side.
interface datapath_sequencer_if #(
  parameter int W = 4
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_data;
  logic         busy;
  logic         done;
  logic [W-1:0] x;
  logic         l1;
  logic         l2;
  logic [1:0]   s1;
  logic [1:0]   s2;
  logic         f;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, x, l1, l2, s1, s2, f
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, x, l1, l2, s1, s2, f
  );
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Accepts one command at a time and runs it on the two-register datapath as
//   a sequence of single-cycle register-transfer steps, then pulses done.
//   Ports:
//     clk        rising-edge clock shared with the datapath registers
//     rst_n      asynchronous active-low reset
//     bus        datapath_sequencer_if.slave (command handshake + control word)
//     dbg_state  current FSM state (0 = IDLE, 1 = EXEC, 2 = DONE)
//   All outputs decode registered state only; no input reaches an output
//   combinationally.
module datapath_sequencer #(
  parameter int W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  datapath_sequencer_if.slave   bus,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LD1  = 3'd1;
  localparam logic [2:0] OP_LD2  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_CLR  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // Bus select encodings.
  localparam logic [1:0] SEL_X    = 2'd0;
  localparam logic [1:0] SEL_R1   = 2'd1;
  localparam logic [1:0] SEL_R2   = 2'd2;
  localparam logic [1:0] SEL_ZERO = 2'd3;

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   op;
  logic [W-1:0] xreg;
  logic [W-1:0] cnt;
  logic [1:0]   step;
  logic         accept;
  logic         last_step;

  logic         l1;
  logic         l2;
  logic [1:0]   s1;
  logic [1:0]   s2;
  logic         f;

  assign accept = bus.cmd_valid && (state == IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Command registers and step/repeat counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xreg <= '0;
      op   <= OP_NOP;
      step <= 2'd0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            xreg <= bus.cmd_data;
            op   <= bus.cmd_op;
            step <= 2'd0;
            cnt  <= bus.cmd_data;
          end
        end
        EXEC: begin
          if (op == OP_MUL) begin
            // MUL only distinguishes the clear step (0) from loop steps (1).
            step <= 2'd1;
            if (step != 2'd0) begin
              cnt <= cnt - W'(1);
            end
          end else begin
            step <= step + 2'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Last-step detection for the current op.
  always_comb begin
    last_step = 1'b1;
    case (op)
      OP_SWAP: last_step = (step == 2'd2);
      // The clear step is last when the loop count is zero; otherwise the
      // loop ends on the step where the remaining count is one.
      OP_MUL:  last_step = (step == 2'd0) ? (xreg == '0) : (cnt == W'(1));
      default: last_step = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (bus.cmd_op == OP_NOP) ? DONE : EXEC;
        end
      end
      EXEC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control word decode; idle word outside EXEC.
  always_comb begin
    l1 = 1'b0;
    l2 = 1'b0;
    s1 = SEL_ZERO;
    s2 = SEL_ZERO;
    f  = 1'b0;
    if (state == EXEC) begin
      case (op)
        OP_LD1: begin
          s1 = SEL_X;
          l1 = 1'b1;
        end
        OP_LD2: begin
          s1 = SEL_X;
          l2 = 1'b1;
        end
        OP_ADD: begin
          s1 = SEL_R1;
          s2 = SEL_R2;
          l1 = 1'b1;
        end
        OP_SUB: begin
          s1 = SEL_R1;
          s2 = SEL_R2;
          f  = 1'b1;
          l1 = 1'b1;
        end
        OP_SWAP: begin
          // a,b -> a+b,b -> a+b,a -> b,a
          s1 = SEL_R1;
          s2 = SEL_R2;
          case (step)
            2'd0: l1 = 1'b1;
            2'd1: begin
              f  = 1'b1;
              l2 = 1'b1;
            end
            default: begin
              f  = 1'b1;
              l1 = 1'b1;
            end
          endcase
        end
        OP_CLR: begin
          l1 = 1'b1;
          l2 = 1'b1;
        end
        OP_MUL: begin
          // Step 0 zeroes R2 via the zero/zero sum; loop steps accumulate R1.
          l2 = 1'b1;
          if (step != 2'd0) begin
            s1 = SEL_R2;
            s2 = SEL_R1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.l1        = l1;
  assign bus.l2        = l2;
  assign bus.s1        = s1;
  assign bus.s2        = s2;
  assign bus.f         = f;
  assign bus.x         = xreg;
  assign bus.cmd_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer
//   Drives datapath_sequencer with directed and random commands. A small
//   register-file datapath is driven by the DUT control word; a command-level
//   model predicts final register values, step counts, load counts and the
//   cycle-by-cycle handshake/status outputs.
module tb_datapath_sequencer;
  localparam int W = 4;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] LD1  = 3'd1;
  localparam logic [2:0] LD2  = 3'd2;
  localparam logic [2:0] ADD  = 3'd3;
  localparam logic [2:0] SUB  = 3'd4;
  localparam logic [2:0] SWAP = 3'd5;
  localparam logic [2:0] CLR  = 3'd6;
  localparam logic [2:0] MUL  = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  datapath_sequencer_if #(.W(W)) bus ();
  logic [1:0] dbg_state;

  datapath_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- datapath driven by the control word ----------------
  logic [3:0] r1 = 4'd0;
  logic [3:0] r2 = 4'd0;

  function automatic logic [3:0] pick(input logic [1:0] s);
    case (s)
      2'd0:    return bus.x;
      2'd1:    return r1;
      2'd2:    return r2;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] alu_out();
    if (bus.f) return 4'(pick(bus.s1) - pick(bus.s2));
    return 4'(pick(bus.s1) + pick(bus.s2));
  endfunction

  always @(posedge clk) begin
    if (bus.l1) r1 <= alu_out();
    if (bus.l2) r2 <= alu_out();
  end

  // ---------------- command-level reference model ----------------
  typedef struct packed {
    logic [3:0] r1;
    logic [3:0] r2;
    int         n;
    int         c1;
    int         c2;
  } exp_t;

  function automatic exp_t predict(input logic [2:0] op, input logic [3:0] d,
                                   input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    e.r1 = a;
    e.r2 = b;
    e.n  = 1;
    e.c1 = 0;
    e.c2 = 0;
    case (op)
      NOP:  e.n = 0;
      LD1:  begin e.r1 = d; e.c1 = 1; end
      LD2:  begin e.r2 = d; e.c2 = 1; end
      ADD:  begin e.r1 = 4'(a + b); e.c1 = 1; end
      SUB:  begin e.r1 = 4'(a - b); e.c1 = 1; end
      SWAP: begin e.r1 = b; e.r2 = a; e.n = 3; e.c1 = 2; e.c2 = 1; end
      CLR:  begin e.r1 = 4'd0; e.r2 = 4'd0; e.c1 = 1; e.c2 = 1; end
      default: begin
        e.r2 = 4'(a * d);
        e.n  = 1 + int'(d);
        e.c2 = 1 + int'(d);
      end
    endcase
    return e;
  endfunction

  logic       m_active = 1'b0;
  int         m_cyc = 0;       // cycle index since accept, 1 = first cycle after the accept edge
  logic [3:0] m_x = 4'd0;
  logic [3:0] m_r1 = 4'd0;
  logic [3:0] m_r2 = 4'd0;
  logic       m_known = 1'b1;  // registers predictable (cleared by reset mid-command)
  exp_t       m_e = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (m_active) m_known <= 1'b0;
      m_active <= 1'b0;
      m_cyc    <= 0;
      m_x      <= 4'd0;
    end else if (!m_active) begin
      if (bus.cmd_valid) begin
        m_active <= 1'b1;
        m_cyc    <= 1;
        m_x      <= bus.cmd_data;
        m_e      <= predict(bus.cmd_op, bus.cmd_data, m_r1, m_r2);
        m_r1     <= predict(bus.cmd_op, bus.cmd_data, m_r1, m_r2).r1;
        m_r2     <= predict(bus.cmd_op, bus.cmd_data, m_r1, m_r2).r2;
        if (bus.cmd_op == CLR) m_known <= 1'b1;
      end
    end else begin
      if (m_cyc >= m_e.n + 1) m_active <= 1'b0;
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  logic exp_done;
  logic in_exec;
  int   c1 = 0;
  int   c2 = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_done = m_active && (m_cyc == m_e.n + 1);
      in_exec  = m_active && (m_cyc <= m_e.n);
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("done", 32'(bus.done), 32'(exp_done));
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_active));
      chk("x", 32'(bus.x), 32'(m_x));
      if (!in_exec) begin
        chk("idle_word", 32'({bus.l1, bus.l2, bus.s1, bus.s2, bus.f}), 32'h1E);
      end
      if (m_active) begin
        if (m_cyc == 1) begin
          c1 = int'(bus.l1);
          c2 = int'(bus.l2);
        end else begin
          c1 += int'(bus.l1);
          c2 += int'(bus.l2);
        end
      end
      if (exp_done) begin
        chk("l1_count", c1, m_e.c1);
        chk("l2_count", c2, m_e.c2);
        if (m_known) begin
          chk("r1_final", 32'(r1), 32'(m_r1));
          chk("r2_final", 32'(r2), 32'(m_r2));
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] d, input bit hold,
                        output int done_c, output int exec_c, output int busy_c);
    int w;
    done_c = 0;
    exec_c = 0;
    busy_c = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    w = 0;
    while (!bus.cmd_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      bus.cmd_data = 4'($urandom_range(0, 15));
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'($urandom_range(0, 7));
      bus.cmd_data  = 4'($urandom_range(0, 15));
    end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.busy) busy_c++;
      if (bus.busy && !bus.done) exec_c++;
      if (bus.done) begin
        done_c = i;
        break;
      end
    end
    if (done_c == 0) chk("done_timeout", 32'(bus.done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  int dc, ec, bc;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_data  = 4'd0;

    // Reset asserted mid-cycle: idle outputs immediately.
    #13 rst_n = 1'b0;
    #1;
    chk("rst_idle_word", 32'({bus.l1, bus.l2, bus.s1, bus.s2, bus.f}), 32'h1E);
    chk("rst_x", 32'(bus.x), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // LD1 5, LD2 3, ADD
    do_cmd(LD1, 4'd5, 1'b0, dc, ec, bc); chk("ld1_done_cyc", dc, 2);
    do_cmd(LD2, 4'd3, 1'b0, dc, ec, bc); chk("ld2_done_cyc", dc, 2);
    do_cmd(ADD, 4'd0, 1'b0, dc, ec, bc); chk("add_done_cyc", dc, 2);
    chk("add_r1", 32'(r1), 32'd8);
    chk("add_r2", 32'(r2), 32'd3);

    // Wrap-around
    do_cmd(LD1, 4'd3, 1'b0, dc, ec, bc);
    do_cmd(LD2, 4'd5, 1'b0, dc, ec, bc);
    do_cmd(SUB, 4'd0, 1'b0, dc, ec, bc);
    chk("sub_wrap_r1", 32'(r1), 32'd14);
    do_cmd(ADD, 4'd0, 1'b0, dc, ec, bc);
    chk("add_wrap_r1", 32'(r1), 32'd3);

    // SWAP with cmd_valid held through busy
    do_cmd(LD1, 4'd9, 1'b0, dc, ec, bc);
    do_cmd(LD2, 4'd4, 1'b0, dc, ec, bc);
    do_cmd(SWAP, 4'd0, 1'b1, dc, ec, bc);
    chk("swap_r1", 32'(r1), 32'd4);
    chk("swap_r2", 32'(r2), 32'd9);
    chk("swap_busy_cyc", bc, 4);
    chk("swap_done_cyc", dc, 4);
    do_cmd(NOP, 4'd7, 1'b0, dc, ec, bc);
    chk("nop_done_cyc", dc, 1);

    // MUL
    do_cmd(LD1, 4'd3, 1'b0, dc, ec, bc);
    do_cmd(MUL, 4'd5, 1'b0, dc, ec, bc);
    chk("mul5_r2", 32'(r2), 32'd15);
    chk("mul5_exec", ec, 6);
    chk("mul5_r1", 32'(r1), 32'd3);
    do_cmd(MUL, 4'd0, 1'b0, dc, ec, bc);
    chk("mul0_r2", 32'(r2), 32'd0);
    chk("mul0_exec", ec, 1);
    do_cmd(LD1, 4'd2, 1'b0, dc, ec, bc);
    do_cmd(MUL, 4'd15, 1'b0, dc, ec, bc);
    chk("mul15_r2", 32'(r2), 32'd14);
    chk("mul15_exec", ec, 16);
    chk("mul15_r1", 32'(r1), 32'd2);

    // Reset during MUL loop step 3
    do_cmd(LD1, 4'd3, 1'b0, dc, ec, bc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = MUL;
    bus.cmd_data  = 4'd5;
    for (int i = 0; i < 10 && !bus.cmd_ready; i++) @(negedge clk);
    chk("mul_rst_accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midmul_idle_word", 32'({bus.l1, bus.l2, bus.s1, bus.s2, bus.f}), 32'h1E);
    chk("midmul_busy", 32'(bus.busy), 32'd0);
    chk("midmul_ready", 32'(bus.cmd_ready), 32'd1);
    chk("midmul_x", 32'(bus.x), 32'd0);
    chk("midmul_r2", 32'(r2), 32'd6);
    repeat (2) @(negedge clk);
    chk("midmul_no_load_r2", 32'(r2), 32'd6);
    chk("midmul_no_load_r1", 32'(r1), 32'd3);
    rst_n = 1'b1;
    do_cmd(CLR, 4'd0, 1'b0, dc, ec, bc);
    chk("clr_done_cyc", dc, 2);
    chk("clr_r1", 32'(r1), 32'd0);
    chk("clr_r2", 32'(r2), 32'd0);

    // Random commands, gaps and held valid
    for (int k = 0; k < 150; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), dc, ec, bc);
    end

    bus.cmd_valid = 1'b0;
    repeat (25) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
